uart_tx: RTL
============

Name: uart_tx

Overview:
8N1 UART transmitter; the serializing counterpart of the team's uart_rx. Accepts bytes over a valid/ready handshake into a one-entry holding register, then shifts them onto tx_serial. Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts DIVISOR clocks. Sits between the host-side byte source and the pad; its output connects directly to a uart_rx with the same parameters for loopback.

Parameters:
CLK_FREQ, 50_000_000, input clock frequency in Hz
BAUD_RATE, 115200, line bit rate in bits/s; DIVISOR = CLK_FREQ/BAUD_RATE (integer division, truncating)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_  input  1  reset; synchronous, active-high (asserted = 1); one clock, sampled on clk only
tx_data  input  8  byte to send; sampled on acceptance edge
tx_valid  input  1  source has a byte; must hold tx_data stable until accepted
tx_ready  output  1  holding register empty; registered
tx_serial  output  1  serial line, idle high; registered
tx_busy  output  1  frame in progress or byte pending
tx_done  output  1  one-cycle pulse when a stop bit completes

Behaviour:
- Reset (rst_=1 at an edge): tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, holding register empty. Applies mid-frame: the line returns high the cycle after the reset edge, the pending byte is discarded, no tx_done.
- Acceptance: tx_valid && tx_ready at an edge. tx_data is captured into the hold register; hold_valid=1; tx_ready=0 next cycle. tx_ready = !hold_valid (from a flop). tx_valid while tx_ready=0 is ignored.
- FSM states are IDLE, START, DATA, STOP. The baud counter runs 0..DIVISOR-1; tick = (cnt == DIVISOR-1), then cnt wraps to 0. The counter is held at 0 in IDLE.
- IDLE: if hold_valid, load the shifter from hold, clear hold_valid, drive tx_serial<=0, go to START. Latency: acceptance in cycle A gives tx_serial low from cycle A+2.
- START: tx_serial=0. On tick, drive data bit 0 and go to DATA with bit index 0.
- DATA: on tick, shift right and output the next bit. After bit index 7 ticks, drive tx_serial<=1 and go to STOP. There is no wrap past 7.
- STOP: tx_serial=1. On tick, pulse tx_done for one cycle.
  - If hold_valid is set at that tick edge: load the shifter, drive tx_serial<=0, go directly to START. There is zero idle gap between frames.
  - Otherwise go to IDLE.
- Frame length is exactly 10*DIVISOR cycles. Each bit's level is constant for exactly DIVISOR cycles.
- tx_busy = (state != IDLE) || hold_valid, combinational from flops.
- Simultaneous accept and consume cannot occur, because tx_ready is 0 whenever hold_valid is 1.
- Counter width is $clog2(DIVISOR). Elaboration assertion: DIVISOR >= 2.

Decomposition:
- Shared package uart_pkg, also to be adopted by uart_rx:
  - state_t enum {IDLE, START, DATA, STOP}
  - constants DATA_BITS=8, FRAME_BITS=10
  - function uart_divisor(clk_freq, baud_rate)
- One natural sub-module: uart_baud_tick, parameterized by DIVISOR.
  - Inputs: clk, rst_, clear.
  - Output: tick.
  - Reusable by uart_rx.
- The FSM, hold register and shifter stay in uart_tx.

Test Plan:
All tests run with CLK_FREQ=1_000_000 and BAUD_RATE=100_000, so DIVISOR=10 and a frame is 100 cycles.
1. Reset held 3 cycles, then released -> tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0 throughout; the line stays high for 200 idle cycles.
2. Send 0xA5, accepted in cycle A -> tx_serial=0 in cycles A+2..A+11. Then bits 1,0,1,0,0,1,0,1, 10 cycles each. Then stop high A+92..A+101. tx_done=1 only in A+102. tx_busy low from A+102.
3. Back-to-back 0x00 then 0xFF; the second is offered at A+5 -> tx_ready is low A+1 only, high at A+2, and accepts the second at A+5. Second start bit begins at A+102 with no gap. The second tx_done pulse occurs at A+202.
4. tx_valid held high with tx_data changing while tx_ready=0 -> only the value present on the acceptance edge is transmitted; exactly one byte per ready-high acceptance.
5. Reset asserted in the DATA state, bit 4 of 0x3C -> tx_serial=1 the cycle after the reset edge; no tx_done; pending hold byte dropped; a subsequent 0x55 transmits correctly.
6. Loopback into uart_rx with the same parameters: 256 bytes 0x00..0xFF sent back-to-back -> rx_data sequence matches, 256 rx_valid pulses, rx_error never asserted.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: the framing FSM state type,
//               frame geometry constants and the baud divisor helper.
//               Used by uart_tx and uart_rx.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Clocks per bit; truncating division.
    function automatic int uart_divisor(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Free-running bit-period counter. Counts 0..DIVISOR-1 and
//               raises tick while the count sits at DIVISOR-1, then wraps.
//               clear holds the count at zero so a new bit period starts
//               cleanly the cycle after clear drops.
// Ports       : clk   - clock, rising edge
//               rst_  - synchronous active-high reset
//               clear - hold counter at zero
//               tick  - high in the last cycle of each bit period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIVISOR = 434
) (
    input  logic clk,
    input  logic rst_,
    input  logic clear,
    output logic tick
);

    localparam int                 C_CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(DIVISOR - 1);

    generate
        if (DIVISOR < 2) begin : g_divisor_check
            $error("uart_baud_tick: DIVISOR must be at least 2");
        end
    endgenerate

    logic [C_CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (rst_ || clear) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter. A one-entry holding register accepts
//               bytes over valid/ready; the framing FSM shifts them out LSB
//               first between a low start bit and a high stop bit. A byte
//               waiting in the holding register at the end of a stop bit
//               starts the next frame with no idle gap.
// Ports       : clk       - clock, rising edge
//               rst_      - synchronous active-high reset
//               tx_data   - byte to send, captured on acceptance
//               tx_valid  - source offers tx_data
//               tx_ready  - holding register empty (registered)
//               tx_serial - serial line, idle high (registered)
//               tx_busy   - frame in progress or byte pending
//               tx_done   - one-cycle pulse after each stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int                 C_DIVISOR = uart_divisor(CLK_FREQ, BAUD_RATE);
    localparam int                 C_IDX_W   = $clog2(DATA_BITS);
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(DATA_BITS - 1);

    state_t                 r_state;
    logic [DATA_BITS-1:0]   r_hold;
    logic                   r_hold_valid;
    logic [DATA_BITS-1:0]   r_shift;
    logic [C_IDX_W-1:0]     r_bit_idx;
    logic                   r_ready;
    logic                   r_serial;
    logic                   r_done;

    logic                   w_tick;
    logic                   w_clear;
    logic                   w_accept;

    // Bit timing only runs while a frame is on the line.
    assign w_clear  = (r_state == IDLE);
    assign w_accept = tx_valid && r_ready;

    uart_baud_tick #(
        .DIVISOR (C_DIVISOR)
    ) u_baud_tick (
        .clk   (clk),
        .rst_  (rst_),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_ready      <= 1'b1;
            r_serial     <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Accept never coincides with a consume: ready is low while the
            // holding register is occupied.
            if (w_accept) begin
                r_hold       <= tx_data;
                r_hold_valid <= 1'b1;
                r_ready      <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (r_hold_valid) begin
                        r_shift      <= r_hold;
                        r_hold_valid <= 1'b0;
                        r_ready      <= 1'b1;
                        r_serial     <= 1'b0;
                        r_state      <= START;
                    end
                end

                START: begin
                    if (w_tick) begin
                        r_serial  <= r_shift[0];
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end
                end

                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == C_LAST_IDX) begin
                            r_serial <= 1'b1;
                            r_state  <= STOP;
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_serial  <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (w_tick) begin
                        r_done <= 1'b1;
                        if (r_hold_valid) begin
                            // Next byte already waiting: back-to-back frame.
                            r_shift      <= r_hold;
                            r_hold_valid <= 1'b0;
                            r_ready      <= 1'b1;
                            r_serial     <= 1'b0;
                            r_state      <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_ready  = r_ready;
    assign tx_serial = r_serial;
    assign tx_done   = r_done;
    assign tx_busy   = (r_state != IDLE) || r_hold_valid;

endmodule
`default_nettype wire
